bp_delta_mac: RTL and testbench

BP_DELTA_MAC -- requirements
Module: bp_delta_mac

---
 rtl/bp_pkg.sv | 25 ++
 rtl/bp_delta_mac_if.sv | 36 +++
 rtl/fxp_mult.sv | 39 +++
 rtl/bp_delta_mac.sv | 179 +++++++++++++++++
 tb/tb_bp_delta_mac.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// bp_pkg: shared definitions for the delta multiply-accumulate block.
// Holds the default fixed-point format, the fixed-point value 1.0, the
// FSM state encoding and a width helper used for counter/index sizing.
package bp_pkg;

  localparam int BP_WIDTH = 32;
  localparam int BP_FRAC  = 24;

  // 1.0 in the default fixed-point format
  localparam logic [BP_WIDTH-1:0] BP_ONE = BP_WIDTH'(1) << BP_FRAC;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } bp_state_e;

  // Bit width able to index n items; never returns 0 so one-entry
  // configurations still get a legal vector.
  function automatic int bp_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bp_delta_mac_if.sv
// bp_delta_mac_if: operand/result handshake bundle of bp_delta_mac.
//   master: drives i_start, i_valid, i_dgate, i_weight, i_ready;
//           observes o_ready, o_valid, o_sum, o_idx, o_busy, o_done.
//   slave : the accumulator block itself (opposite directions).
interface bp_delta_mac_if
  import bp_pkg::*;
#(
  parameter int WIDTH   = BP_WIDTH,
  parameter int NUM_OUT = 53
);

  localparam int IDX_W = bp_clog2(NUM_OUT);

  logic                    i_start;
  logic                    i_valid;
  logic signed [WIDTH-1:0] i_dgate;
  logic signed [WIDTH-1:0] i_weight;
  logic                    o_ready;
  logic                    o_valid;
  logic                    i_ready;
  logic signed [WIDTH-1:0] o_sum;
  logic [IDX_W-1:0]        o_idx;
  logic                    o_busy;
  logic                    o_done;

  modport master (
    output i_start, i_valid, i_dgate, i_weight, i_ready,
    input  o_ready, o_valid, o_sum, o_idx, o_busy, o_done
  );

  modport slave (
    input  i_start, i_valid, i_dgate, i_weight, i_ready,
    output o_ready, o_valid, o_sum, o_idx, o_busy, o_done
  );

endinterface

// File: rtl/fxp_mult.sv
// fxp_mult: registered signed fixed-point multiply.
// The full 2*WIDTH product is arithmetic-shifted right by FRAC (rounds
// toward minus infinity) and the low OUT_W bits are registered when i_en
// is high; otherwise the register holds.
//   clk, rst : clock, asynchronous active-high reset
//   i_en     : load a new product
//   i_a, i_b : signed operands, FRAC fractional bits each
//   o_p      : registered product, FRAC fractional bits
// OUT_W must not exceed 2*WIDTH.
module fxp_mult #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 24,
  parameter int OUT_W = 40
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_en,
  input  logic signed [WIDTH-1:0] i_a,
  input  logic signed [WIDTH-1:0] i_b,
  output logic signed [OUT_W-1:0] o_p
);

  logic signed [2*WIDTH-1:0] full_prod;
  logic signed [OUT_W-1:0]   p_d, p_q;

  always_comb begin
    full_prod = i_a * i_b;
    p_d       = p_q;
    if (i_en) p_d = OUT_W'(full_prod >>> FRAC);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) p_q <= '0;
    else     p_q <= p_d;
  end

  assign o_p = p_q;

endmodule

// File: rtl/bp_delta_mac.sv
// bp_delta_mac: back-propagation delta multiply-accumulate.
// Streams NUM_OUT groups of NUM_CELL*NUM_GATE (dgate, weight) pairs and
// returns one fixed-point sum per group, tagged with its index.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : bp_delta_mac_if.slave (start pulse, operand handshake,
//              result handshake, busy and done status)
// Macro BP_DELTA_MAC_SAT_EN: when defined, an accumulator value outside the
// WIDTH range clamps to the signed max/min on o_sum; otherwise o_sum is the
// low WIDTH bits of the accumulator.
// Pipeline: pair -> product register -> accumulator -> output register.
// A held output stalls every stage together, so nothing in flight is lost.
module bp_delta_mac
  import bp_pkg::*;
#(
  parameter int WIDTH    = BP_WIDTH,
  parameter int FRAC     = BP_FRAC,
  parameter int NUM_CELL = 8,
  parameter int NUM_GATE = 4,
  parameter int NUM_OUT  = 53,
  parameter int GUARD    = 8
) (
  input logic           clk,
  input logic           rst,
  bp_delta_mac_if.slave bus
);

  localparam int ACC_W  = WIDTH + GUARD;
  localparam int PPO    = NUM_CELL * NUM_GATE;
  localparam int PAIR_W = bp_clog2(PPO);
  localparam int IDX_W  = bp_clog2(NUM_OUT);

  bp_state_e state_q, state_d;

  logic [PAIR_W-1:0]       pair_q, pair_d;
  logic [IDX_W-1:0]        out_q, out_d;
  logic                    s1_valid_q, s1_valid_d;
  logic                    s1_first_q, s1_first_d;
  logic                    s1_last_q, s1_last_d;
  logic [IDX_W-1:0]        s1_idx_q, s1_idx_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    acc_done_q, acc_done_d;
  logic [IDX_W-1:0]        acc_idx_q, acc_idx_d;
  logic                    o_valid_q, o_valid_d;
  logic signed [WIDTH-1:0] o_sum_q, o_sum_d;
  logic [IDX_W-1:0]        o_idx_q, o_idx_d;

  logic                    run, busy, done;
  logic                    stall, take, last_pair, last_out, final_accept;
  logic signed [ACC_W-1:0] prod;
  logic signed [WIDTH-1:0] sum_out;

  // Output register full and not drained: freeze the whole pipeline.
  always_comb begin
    stall        = o_valid_q && !bus.i_ready;
    take         = run && bus.i_valid && !stall;
    last_pair    = (pair_q == PAIR_W'(PPO - 1));
    last_out     = (out_q == IDX_W'(NUM_OUT - 1));
    final_accept = o_valid_q && bus.i_ready && (o_idx_q == IDX_W'(NUM_OUT - 1));
  end

  fxp_mult #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC),
    .OUT_W (ACC_W)
  ) u_mult (
    .clk  (clk),
    .rst  (rst),
    .i_en (take),
    .i_a  (bus.i_dgate),
    .i_b  (bus.i_weight),
    .o_p  (prod)
  );

  // Accumulator to output width: wrap by default, clamp when enabled.
  always_comb begin
    sum_out = acc_q[WIDTH-1:0];
`ifdef BP_DELTA_MAC_SAT_EN
    if (acc_q[ACC_W-1:WIDTH-1] != {(GUARD + 1){acc_q[ACC_W-1]}})
      sum_out = acc_q[ACC_W-1] ? {1'b1, {(WIDTH - 1){1'b0}}}
                               : {1'b0, {(WIDTH - 1){1'b1}}};
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.i_start) state_d = ST_RUN;
      ST_RUN:   if (take && last_pair && last_out) state_d = ST_DRAIN;
      ST_DRAIN: if (final_accept) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    run  = (state_q == ST_RUN);
    busy = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    done = (state_q == ST_DONE);
  end

  // Counters advance per transferred pair; the stages advance unless stalled.
  // A product tagged "first" reloads the accumulator, and a product tagged
  // "last" marks the accumulator as holding a finished sum for one cycle.
  always_comb begin
    pair_d     = pair_q;
    out_d      = out_q;
    s1_valid_d = s1_valid_q;
    s1_first_d = s1_first_q;
    s1_last_d  = s1_last_q;
    s1_idx_d   = s1_idx_q;
    acc_d      = acc_q;
    acc_done_d = acc_done_q;
    acc_idx_d  = acc_idx_q;
    o_valid_d  = o_valid_q;
    o_sum_d    = o_sum_q;
    o_idx_d    = o_idx_q;
    if (take) begin
      pair_d = last_pair ? '0 : pair_q + 1'b1;
      if (last_pair) out_d = last_out ? '0 : out_q + 1'b1;
    end
    if (!stall) begin
      s1_valid_d = take;
      s1_first_d = (pair_q == '0);
      s1_last_d  = last_pair;
      s1_idx_d   = out_q;
      acc_done_d = 1'b0;
      if (s1_valid_q) begin
        acc_d      = s1_first_q ? prod : acc_q + prod;
        acc_done_d = s1_last_q;
        acc_idx_d  = s1_idx_q;
      end
      o_valid_d = acc_done_q;
      if (acc_done_q) begin
        o_sum_d = sum_out;
        o_idx_d = acc_idx_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pair_q     <= '0;
      out_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_idx_q   <= '0;
      acc_q      <= '0;
      acc_done_q <= 1'b0;
      acc_idx_q  <= '0;
      o_valid_q  <= 1'b0;
      o_sum_q    <= '0;
      o_idx_q    <= '0;
    end else begin
      state_q    <= state_d;
      pair_q     <= pair_d;
      out_q      <= out_d;
      s1_valid_q <= s1_valid_d;
      s1_first_q <= s1_first_d;
      s1_last_q  <= s1_last_d;
      s1_idx_q   <= s1_idx_d;
      acc_q      <= acc_d;
      acc_done_q <= acc_done_d;
      acc_idx_q  <= acc_idx_d;
      o_valid_q  <= o_valid_d;
      o_sum_q    <= o_sum_d;
      o_idx_q    <= o_idx_d;
    end
  end

  assign bus.o_ready = run && !stall;
  assign bus.o_valid = o_valid_q;
  assign bus.o_sum   = o_sum_q;
  assign bus.o_idx   = o_idx_q;
  assign bus.o_busy  = busy;
  assign bus.o_done  = done;

endmodule

// File: tb/tb_bp_delta_mac.sv
// tb_bp_delta_mac: table-driven bench for bp_delta_mac with a result
// scoreboard. Each table row is one full pass with a constant operand pair
// and the hand-derived per-output sum; expected results are queued as the
// last pair of each output transfers and popped when the DUT hands a result
// over. Extra sequences cover a start pulse during a pass, output
// backpressure and reset in the middle of a pass.
module tb_bp_delta_mac;
  import bp_pkg::*;

  localparam int WIDTH    = 32;
  localparam int FRAC     = 24;
  localparam int NUM_CELL = 2;
  localparam int NUM_GATE = 4;
  localparam int NUM_OUT  = 3;
  localparam int GUARD    = 16;
  localparam int PPO      = NUM_CELL * NUM_GATE;
  localparam int IDX_W    = bp_clog2(NUM_OUT);

  typedef struct {
    logic [WIDTH-1:0] dgate;
    logic [WIDTH-1:0] weight;
    logic [WIDTH-1:0] exp_sum;
  } vec_t;

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] sum;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_acc_cyc = 0;
  int   n_results = 0;
  res_t sb[$];
  vec_t vecs[8];

  always #5 clk = ~clk;

  bp_delta_mac_if #(.WIDTH(WIDTH), .NUM_OUT(NUM_OUT)) bus ();

  bp_delta_mac #(
    .WIDTH    (WIDTH),
    .FRAC     (FRAC),
    .NUM_CELL (NUM_CELL),
    .NUM_GATE (NUM_GATE),
    .NUM_OUT  (NUM_OUT),
    .GUARD    (GUARD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    n_cmp++;
    n_fail++;
    $display("[TB] FAIL %s: bound expired", name);
  endtask

  always @(posedge clk) cyc++;

  // Result monitor: a result handed over at the next edge is checked here.
  always @(negedge clk) begin
    res_t e;
    if (!rst && bus.o_valid && bus.i_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL unexpected_result: got idx %0d sum %h, expected none", bus.o_idx, bus.o_sum);
      end else begin
        e = sb.pop_front();
        checkOutput("sum", bus.o_sum, e.sum);
        checkOutput("idx", 32'(bus.o_idx), 32'(e.idx));
      end
      last_acc_cyc = cyc;
      n_results++;
    end
    if (!rst && bus.o_done)
      checkOutput("done_timing", 32'(cyc - last_acc_cyc), 32'd1);
  end

  // Start a pass and stream pairs until the pass is complete or stop_after
  // pairs have transferred; optionally pulses i_start mid-pass.
  task automatic applyStimulus(input logic [31:0] dg, input logic [31:0] wt,
                               input logic [31:0] exp, input int stop_after,
                               input bit spurious);
    int sent = 0;
    int k = 0;
    @(posedge clk); #1;
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    checkOutput("busy_run", 32'(bus.o_busy), 32'd1);
    while (sent < NUM_OUT * PPO && sent != stop_after && k < 2000) begin
      bus.i_valid  = 1'b1;
      bus.i_dgate  = dg;
      bus.i_weight = wt;
      bus.i_start  = spurious && (sent == 3);
      @(negedge clk);
      if (bus.o_ready) begin
        sent++;
        if (sent % PPO == 0) sb.push_back('{idx: IDX_W'(sent / PPO - 1), sum: exp});
      end
      @(posedge clk); #1;
      k++;
    end
    bus.i_valid = 1'b0;
    bus.i_start = 1'b0;
    if (k >= 2000) failNow("pair_stream");
  endtask

  task automatic waitDone(input int res_base);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.o_done && k < 300);
    if (!bus.o_done) failNow("wait_done");
    else begin
      checkOutput("results_per_pass", 32'(n_results - res_base), 32'(NUM_OUT));
      checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
      @(negedge clk);
      checkOutput("done_one_cycle", 32'(bus.o_done), 32'd0);
      checkOutput("busy_idle", 32'(bus.o_busy), 32'd0);
    end
  endtask

  // Hold i_ready low for 10 cycles once a result is presented.
  task automatic bpHold();
    logic [31:0] held;
    int k = 0;
    while (!bus.o_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!bus.o_valid) failNow("bp_wait_valid");
    else begin
      held = bus.o_sum;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        checkOutput("bp_sum_stable", bus.o_sum, held);
        checkOutput("bp_ready_low", 32'(bus.o_ready), 32'd0);
        checkOutput("bp_valid_held", 32'(bus.o_valid), 32'd1);
      end
    end
    @(posedge clk); #1;
    bus.i_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    bus.i_start  = 1'b0;
    bus.i_valid  = 1'b0;
    bus.i_dgate  = '0;
    bus.i_weight = '0;
    bus.i_ready  = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid", 32'(bus.o_valid), 32'd0);
    checkOutput("rst_ready", 32'(bus.o_ready), 32'd0);
    checkOutput("rst_busy", 32'(bus.o_busy), 32'd0);
    checkOutput("rst_done", 32'(bus.o_done), 32'd0);
    checkOutput("rst_sum", bus.o_sum, 32'd0);
    checkOutput("rst_idx", 32'(bus.o_idx), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    vecs[0] = '{BP_ONE,       BP_ONE,       32'h0800_0000};
    vecs[1] = '{32'hFF000000, 32'h00800000, 32'hFC00_0000};
    vecs[2] = '{32'h00400000, 32'hFFC00000, 32'hFF80_0000};
    vecs[3] = '{32'h00000001, 32'hFFFFFFFF, 32'hFFFF_FFF8};
    vecs[4] = '{32'h00000001, 32'h00000001, 32'h0000_0000};
`ifdef BP_DELTA_MAC_SAT_EN
    vecs[5] = '{32'h7F000000, 32'h7F000000, 32'h7FFF_FFFF};
    vecs[6] = '{32'h80000000, 32'h80000000, 32'h7FFF_FFFF};
    vecs[7] = '{32'h80000000, 32'h7F000000, 32'h8000_0000};
`else
    vecs[5] = '{32'h7F000000, 32'h7F000000, 32'h0800_0000};
    vecs[6] = '{32'h80000000, 32'h80000000, 32'h0000_0000};
    vecs[7] = '{32'h80000000, 32'h7F000000, 32'h0000_0000};
`endif

    for (int i = 0; i < 8; i++) begin
      base = n_results;
      applyStimulus(vecs[i].dgate, vecs[i].weight, vecs[i].exp_sum, -1, 1'b0);
      waitDone(base);
    end

    $display("[TB] start pulse during a pass");
    base = n_results;
    applyStimulus(BP_ONE, BP_ONE, 32'h0800_0000, -1, 1'b1);
    waitDone(base);

    $display("[TB] output backpressure");
    base = n_results;
    bus.i_ready = 1'b0;
    fork
      applyStimulus(BP_ONE, BP_ONE, 32'h0800_0000, -1, 1'b0);
      bpHold();
    join
    waitDone(base);

    $display("[TB] reset in the middle of a pass");
    applyStimulus(BP_ONE, BP_ONE, 32'h0800_0000, 5, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_busy", 32'(bus.o_busy), 32'd0);
    checkOutput("midrst_valid", 32'(bus.o_valid), 32'd0);
    checkOutput("midrst_ready", 32'(bus.o_ready), 32'd0);
    checkOutput("midrst_sum", bus.o_sum, 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    base = n_results;
    applyStimulus(BP_ONE, BP_ONE, 32'h0800_0000, -1, 1'b0);
    waitDone(base);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
